// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: row sense lines in, column drive and one-hot key code out.
// The master side is the scanner; the slave side is the keypad/keyPadCtrl end.
interface keypad_scanner_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [7:0] key_code;
  logic       key_valid;

  modport master (input rows, output cols, output key_code, output key_valid);
  modport slave  (output rows, input cols, input key_code, input key_valid);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce, feeding keyPadCtrl's keyPadInput bus.
// Drives one column at a time, samples the synchronized rows at the end of each
// column dwell, debounces press and release, and emits {col, row} one-hot codes
// for a fixed hold time. Define KEYPAD_AUTOREPEAT_EN to re-emit a key that stays
// held for REPEAT_SAMPLES samples; that parameter exists only in that build.
module keypad_scanner #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3,
  parameter int HOLD_CYCLES  = 4
`ifdef KEYPAD_AUTOREPEAT_EN
  , parameter int REPEAT_SAMPLES = 64
`endif
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scanner_if.master kp_if
);

  localparam int DIV_W  = $clog2(SCAN_DIV) + 1;
  localparam int DEB_W  = $clog2(DEBOUNCE_CNT) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CNT);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_SAMPLES) + 1;
  localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_SAMPLES);
`endif

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] EMIT     = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  logic [3:0]        rowsMeta_q, rowsSync_q;
  logic [1:0]        state_q, state_d;
  logic [DIV_W-1:0]  divCnt_q, divCnt_d;
  logic [3:0]        cols_q, cols_d;
  logic [7:0]        cand_q, cand_d;
  logic [DEB_W-1:0]  matchCnt_q, matchCnt_d;
  logic [DEB_W-1:0]  relCnt_q, relCnt_d;
  logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
  logic [7:0]        keyCode_q, keyCode_d;
  logic              keyValid_q, keyValid_d;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [RPT_W-1:0]  rptCnt_q, rptCnt_d;
`endif

  logic       sampleTick;
  logic       sampleOneHot;
  logic [3:0] sample;
  logic [3:0] colsRot;

  assign sample       = rowsSync_q;
  assign sampleTick   = (state_q != EMIT) && (divCnt_q == DIV_LAST);
  assign sampleOneHot = (sample != 4'd0) && ((sample & (sample - 4'd1)) == 4'd0);
  assign colsRot      = {cols_q[2:0], cols_q[3]};

  assign kp_if.cols      = cols_q;
  assign kp_if.key_code  = keyCode_q;
  assign kp_if.key_valid = keyValid_q;

  // Two-flop synchronizer for the asynchronous row lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rowsMeta_q <= 4'd0;
      rowsSync_q <= 4'd0;
    end else begin
      rowsMeta_q <= kp_if.rows;
      rowsSync_q <= rowsMeta_q;
    end
  end

  // Column dwell counter, paused while a key is being emitted
  always_comb begin
    divCnt_d = divCnt_q;
    if (state_q != EMIT) begin
      divCnt_d = sampleTick ? '0 : divCnt_q + DIV_W'(1);
    end
  end

  // Scan / debounce / emit / release sequencing
  always_comb begin
    state_d    = state_q;
    cols_d     = cols_q;
    cand_d     = cand_q;
    matchCnt_d = matchCnt_q;
    relCnt_d   = relCnt_q;
    holdCnt_d  = holdCnt_q;
    keyCode_d  = keyCode_q;
    keyValid_d = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rptCnt_d   = rptCnt_q;
`endif
    case (state_q)
      SCAN: begin
        if (sampleTick) begin
          if (sampleOneHot) begin
            cand_d     = {cols_q, sample};
            matchCnt_d = DEB_W'(1);
            if (DEBOUNCE_CNT == 1) begin
              state_d    = EMIT;
              matchCnt_d = '0;
              keyCode_d  = {cols_q, sample};
              keyValid_d = 1'b1;
              holdCnt_d  = HOLD_W'(1);
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            cols_d = colsRot;
          end
        end
      end
      DEBOUNCE: begin
        if (sampleTick) begin
          if (sample == cand_q[3:0]) begin
            matchCnt_d = matchCnt_q + DEB_W'(1);
            if (matchCnt_q + DEB_W'(1) == DEB_MAX) begin
              state_d    = EMIT;
              matchCnt_d = '0;
              keyCode_d  = cand_q;
              keyValid_d = 1'b1;
              holdCnt_d  = HOLD_W'(1);
            end
          end else begin
            state_d    = SCAN;
            cols_d     = colsRot;
            matchCnt_d = '0;
          end
        end
      end
      EMIT: begin
        if (holdCnt_q == HOLD_MAX) begin
          state_d   = RELEASE;
          keyCode_d = 8'd0;
          holdCnt_d = '0;
          relCnt_d  = '0;
        end else begin
          holdCnt_d = holdCnt_q + HOLD_W'(1);
        end
      end
      RELEASE: begin
        if (sampleTick) begin
          if ((sample & cand_q[3:0]) == 4'd0) begin
`ifdef KEYPAD_AUTOREPEAT_EN
            rptCnt_d = '0;
`endif
            relCnt_d = relCnt_q + DEB_W'(1);
            if (relCnt_q + DEB_W'(1) == DEB_MAX) begin
              state_d  = SCAN;
              cols_d   = colsRot;
              relCnt_d = '0;
            end
          end else begin
            relCnt_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (rptCnt_q + RPT_W'(1) == RPT_MAX) begin
              rptCnt_d   = '0;
              state_d    = EMIT;
              keyCode_d  = cand_q;
              keyValid_d = 1'b1;
              holdCnt_d  = HOLD_W'(1);
            end else begin
              rptCnt_d = rptCnt_q + RPT_W'(1);
            end
`endif
          end
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SCAN;
      divCnt_q   <= '0;
      cols_q     <= 4'b0001;
      cand_q     <= 8'd0;
      matchCnt_q <= '0;
      relCnt_q   <= '0;
      holdCnt_q  <= '0;
      keyCode_q  <= 8'd0;
      keyValid_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rptCnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      divCnt_q   <= divCnt_d;
      cols_q     <= cols_d;
      cand_q     <= cand_d;
      matchCnt_q <= matchCnt_d;
      relCnt_q   <= relCnt_d;
      holdCnt_q  <= holdCnt_d;
      keyCode_q  <= keyCode_d;
      keyValid_q <= keyValid_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rptCnt_q   <= rptCnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: a 16-key matrix model drives the rows from the
// column lines; expected key codes are queued by the stimulus and a monitor
// pops and compares them on every key_valid pulse.
`timescale 1ns/1ps
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] keyMat;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  expQ[$];

  keypad_scanner_if kif();

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_CNT(3),
    .HOLD_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp_if(kif)
  );

  // System clock, 10 ns period
  always #5 clk = ~clk;

  // Key at column c, row r is bit c*4+r; a pressed key connects its column to its row
  assign kif.rows = ({4{kif.cols[0]}} & keyMat[3:0])   | ({4{kif.cols[1]}} & keyMat[7:4]) |
                    ({4{kif.cols[2]}} & keyMat[11:8])  | ({4{kif.cols[3]}} & keyMat[15:12]);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic failTimeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] keys, input int cycles);
    keyMat = keys;
    waitCycles(cycles);
  endtask

  task automatic waitCols(input logic [3:0] target, input string name);
    int n = 0;
    while (kif.cols !== target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (kif.cols !== target) failTimeout(name);
  endtask

  task automatic waitValid(input string name, output int n);
    n = 0;
    while (kif.key_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (kif.key_valid !== 1'b1) failTimeout(name);
  endtask

  // After reset release: first rotation after 4 cycles, then every 4
  task automatic checkRotation(input string tag);
    waitCycles(3);
    checkOutput({tag, "_cols_hold"}, kif.cols, 4'b0001);
    waitCycles(1);
    checkOutput({tag, "_cols_rot1"}, kif.cols, 4'b0010);
    waitCycles(4);
    checkOutput({tag, "_cols_rot2"}, kif.cols, 4'b0100);
  endtask

  // Scoreboard monitor: every emission must match the next queued code
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && kif.key_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_emission: got key_code %0h, expected no emission", kif.key_code);
        end else begin
          checkOutput("emitted_code", kif.key_code, expQ.pop_front());
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence
  initial begin
    int n;
    int h;
    rst    = 1'b1;
    keyMat = 16'd0;
    waitCycles(3);
    checkOutput("reset_cols", kif.cols, 4'b0001);
    checkOutput("reset_key_code", kif.key_code, 8'd0);
    checkOutput("reset_key_valid", kif.key_valid, 1'b0);
    rst = 1'b0;
    checkRotation("reset");

    // Clean press of col0/row3 with latency and hold-length checks
    waitCols(4'b1000, "press_wait_col3");
    keyMat = 16'h0008;
    expQ.push_back(8'h18);
    waitCols(4'b0001, "press_wait_col0");
    n = 0;
    while (kif.key_code == 8'd0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("press_latency", n, 12);
    h = 0;
    while (kif.key_code != 8'd0 && h < 20) begin
      h++;
      @(negedge clk);
    end
    checkOutput("press_hold_cycles", h, 4);
    applyStimulus(16'h0008, 8);
    applyStimulus(16'h0000, 40);

    // Bounce: press then release on the next sample
    waitCols(4'b1000, "bounce1_wait_col3");
    keyMat = 16'h0080;
    waitCols(4'b0010, "bounce1_wait_col1");
    applyStimulus(16'h0080, 4);
    applyStimulus(16'h0000, 2);
    checkOutput("bounce1_frozen", kif.cols, 4'b0010);
    waitCycles(2);
    checkOutput("bounce1_next_col", kif.cols, 4'b0100);

    // Bounce: two matching samples then a release, one short of acceptance
    waitCols(4'b1000, "bounce2_wait_col3");
    keyMat = 16'h0080;
    waitCols(4'b0010, "bounce2_wait_col1");
    applyStimulus(16'h0080, 8);
    applyStimulus(16'h0000, 2);
    checkOutput("bounce2_frozen", kif.cols, 4'b0010);
    waitCycles(2);
    checkOutput("bounce2_next_col", kif.cols, 4'b0100);

    // Ghosting: two rows on col2 must be ignored
    waitCols(4'b0010, "ghost_wait_col1");
    keyMat = 16'h0C00;
    waitCols(4'b0100, "ghost_wait_col2");
    waitCycles(4);
    checkOutput("ghost_rotates", kif.cols, 4'b1000);
    applyStimulus(16'h0C00, 40);
    applyStimulus(16'h0000, 10);

    // Held key col3/row0 for 300 cycles emits once
    waitCols(4'b0100, "held_wait_col2");
    expQ.push_back(8'h81);
    applyStimulus(16'h1000, 300);
    applyStimulus(16'h0000, 40);

    // Release gating: B pressed while A is still held is reported after A
    waitCols(4'b1000, "gate_wait_col3");
    keyMat = 16'h0001;
    expQ.push_back(8'h11);
    expQ.push_back(8'h22);
    waitValid("gate_a_valid", n);
    applyStimulus(16'h0001, 5);
    applyStimulus(16'h0021, 40);
    checkOutput("gate_cols_frozen", kif.cols, 4'b0001);
    keyMat = 16'h0020;
    waitValid("gate_b_valid", n);
    checkOutput("gate_b_after_release", (n >= 12), 1'b1);
    applyStimulus(16'h0020, 10);
    applyStimulus(16'h0000, 40);

    // Reset in the middle of an emission
    waitCols(4'b1000, "midreset_wait_col3");
    keyMat = 16'h0002;
    expQ.push_back(8'h12);
    waitValid("midreset_valid", n);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset_key_code", kif.key_code, 8'd0);
    checkOutput("midreset_key_valid", kif.key_valid, 1'b0);
    checkOutput("midreset_cols", kif.cols, 4'b0001);
    keyMat = 16'h0000;
    waitCycles(2);
    rst = 1'b0;
    checkRotation("midreset");

    waitCycles(20);
    checkOutput("queue_empty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream stage of keyPadCtrl: scans the 4x4 matrix keypad, debounces, and emits one-hot key codes on keyPadCtrl's keyPadInput bus.
- Drives one column at a time and samples the row lines.
- A confirmed key is presented as {column one-hot, row one-hot} for a fixed number of cycles, then the bus is cleared. This matches the hold/gap pattern keyPadCtrl expects.

Parameters:
- SCAN_DIV, 4: clock cycles each column is driven before rows are sampled (>=2).
- DEBOUNCE_CNT, 3: consecutive identical samples needed to accept a press or a release (>=1).
- HOLD_CYCLES, 4: cycles key_code is held non-zero per emitted key (>=1).
- REPEAT_SAMPLES, 64: held-key samples before auto-repeat (used only with the optional feature).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- rows  input  4  keypad row lines, active-high, externally pulled down
- cols  output  4  column drive, one-hot, active-high
- key_code  output  8  [7:4] column one-hot, [3:0] row one-hot; 0 when idle; connects to keyPadInput
- key_valid  output  1  single-cycle pulse on the first cycle of each emission

Behaviour:
- Reset (async assert, sync release):
  - cols=4'b0001, key_code=0, key_valid=0.
  - state=SCAN; all counters 0.
- Sampling:
  - rows is registered through a 2-flop synchronizer.
  - A "sample" is the synchronized rows value on the last cycle of each SCAN_DIV-cycle dwell.
  - The dwell counter runs in every state except EMIT.
- SCAN:
  - After each sample, cols rotates left: 0001->0010->0100->1000->0001.
  - Sample has exactly one bit set: latch cand={cols,sample}, match_cnt=1, freeze cols, go to DEBOUNCE. If DEBOUNCE_CNT==1, go straight to EMIT.
  - Sample has 0 bits or 2+ bits set (ghosting): ignore it and keep rotating.
- DEBOUNCE:
  - cols stays frozen.
  - Sample equals cand[3:0]: match_cnt++. When match_cnt reaches DEBOUNCE_CNT, go to EMIT.
  - Any mismatch: return to SCAN, rotate to the next column, clear match_cnt.
- EMIT:
  - key_code=cand for exactly HOLD_CYCLES cycles.
  - key_valid=1 on the first of those cycles only.
  - Then key_code=0 and go to RELEASE.
- Press latency: key_code goes non-zero on the cycle after the accepting sample, i.e. (DEBOUNCE_CNT-1)*SCAN_DIV+1 cycles after the first detecting sample.
- RELEASE:
  - cols stays frozen and key_code=0.
  - Requires DEBOUNCE_CNT consecutive samples with cand's row bit = 0.
  - A sample with the bit set resets the release count.
  - On completion, rotate cols and go to SCAN.
- Blocking rule: a second key pressed while in RELEASE is not reported until the first key's release completes and that second key is then scanned.
- Registered outputs: key_code and key_valid are registered, so they change only on clk edges.
- key_code invariant: always 0 or exactly one bit set in each nibble.
- Reset mid-operation (any state): outputs return to reset values immediately; no partial emission continues.
- Counter widths: $clog2 of their maxima plus 1; no wrap occurs within the legal parameter ranges.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - In RELEASE, consecutive samples with cand's row bit still set are counted.
  - When the count reaches REPEAT_SAMPLES, re-enter EMIT with the same cand (new key_valid pulse), clear the count and continue.
  - A single released sample clears the repeat count.
- Undefined:
  - No repeat counter is built.
  - A held key emits exactly once per press.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3, HOLD_CYCLES=4 unless noted):
- Reset: assert rst mid-EMIT -> key_code=0, key_valid=0, cols=4'b0001 asynchronously. After release, cols rotates every 4 cycles.
- Clean press: hold rows=4'b1000 while cols=4'b0001 for 20 cycles, then release -> exactly one emission: key_code=8'b00011000 for 4 cycles, one key_valid pulse. key_code goes non-zero 9 cycles after the detecting sample.
- Bounce: rows toggles 1000/0000 on consecutive samples -> no key_valid. SCAN resumes at the next column.
- Ghosting: rows=4'b1100 on any column -> no emission; cols keeps rotating.
- Held key: hold rows=4'b0001 at cols=4'b1000 for 300 cycles:
  - Macro off -> single emission, key_code=8'b10000001.
  - Macro on, REPEAT_SAMPLES=8 -> re-emission every 8 samples (32 cycles) after the first.
- Release gating: press key A, press key B during RELEASE, release A -> B is reported only after 3 released samples of A. The sequence is A then B, each with its own key_valid pulse.
